db9_joy_reader: RTL

- Drives the NeptUNO2 DB9 joystick shift-register chain (2x 74HC165, 16 bits) through JOY_LOAD, JOY_CLK and JOY_DATA.
- Deserialises each frame into two active-high 6-bit joystick words for the C64 core.
- Sits directly upstream of the board top's joystick pins. It replaces the middleboard reflection path when the FPGA scans the joysticks itself.
- Includes a two-frame agreement filter against glitches.

---
 rtl/joy_pkg.sv | 34 +++
 rtl/joy_tick_gen.sv | 26 ++
 rtl/db9_joy_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/joy_pkg.sv
// Shared constants for the DB9 joystick chain reader: joystick word layout,
// frame offsets, FSM state encoding and the frame-to-joystick mapping.
package joy_pkg;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE1  = 4;
  localparam int JOY_FIRE2  = 5;

  localparam int JOY1_BASE  = 0;
  localparam int JOY2_BASE  = 8;
  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {GAP, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_e;

  // The chain delivers up, down, left, right, fire1, fire2 in that order,
  // which differs from the joystick word layout.
  function automatic logic [5:0] frame_to_joy(input logic [FRAME_BITS-1:0] f,
                                              input int base);
    logic [FRAME_BITS-1:0] s;
    logic [5:0]            j;
    s           = f >> base;
    j[JOY_UP]    = s[0];
    j[JOY_DOWN]  = s[1];
    j[JOY_LEFT]  = s[2];
    j[JOY_RIGHT] = s[3];
    j[JOY_FIRE1] = s[4];
    j[JOY_FIRE2] = s[5];
    return j;
  endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Clock divider producing a one-cycle tick every CLK_DIV enabled cycles.
// Holding en_i low freezes the phase so the caller can insert extra cycles.
module joy_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/db9_joy_reader.sv
// Scans the two-74HC165 DB9 joystick chain and produces filtered, active-high
// joystick words plus the raw inverted frame.
module db9_joy_reader #(
  parameter int CLK_DIV   = 4,
  parameter int GAP_TICKS = 2,
  parameter int FILTER    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [5:0]  joy1,
  output logic [5:0]  joy2,
  output logic [15:0] frame_raw,
  output logic        frame_done
);
  import joy_pkg::*;

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_e                state_q;
  logic [GW-1:0]         gap_q;
  logic [3:0]            idx_q;
  logic [1:0]            sync_q;
  logic [FRAME_BITS-1:0] shift_q, prev_q, raw_q;
  logic                  prev_vld_q, load_q, jclk_q, done_q;
  logic [5:0]            joy1_q, joy2_q;

  logic                  tick;
  logic [FRAME_BITS-1:0] frame_d;
  logic [5:0]            joy1_d, joy2_d;
  logic                  take_d;

  // DONE is one extra clk outside the tick grid, so the divider pauses there.
  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (state_q != DONE),
    .tick_o  (tick)
  );

  assign frame_d = ~shift_q;
  assign joy1_d  = frame_to_joy(frame_d, JOY1_BASE);
  assign joy2_d  = frame_to_joy(frame_d, JOY2_BASE);
  assign take_d  = (FILTER == 0) || (prev_vld_q && (frame_d == prev_q));

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], JOY_DATA};
    if (state_q == SHIFT_LO && tick) shift_q[idx_q] <= sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GAP;
      gap_q      <= '0;
      idx_q      <= '0;
      load_q     <= 1'b1;
      jclk_q     <= 1'b1;
      joy1_q     <= '0;
      joy2_q     <= '0;
      raw_q      <= '0;
      done_q     <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        GAP: if (tick) begin
          if (gap_q == GW'(GAP_TICKS - 1)) begin
            gap_q   <= '0;
            load_q  <= 1'b0;
            state_q <= LOAD;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        LOAD: if (tick) begin
          idx_q   <= '0;
          load_q  <= 1'b1;
          jclk_q  <= 1'b0;
          state_q <= SHIFT_LO;
        end
        SHIFT_LO: if (tick) begin
          jclk_q  <= 1'b1;
          state_q <= SHIFT_HI;
        end
        SHIFT_HI: if (tick) begin
          if (idx_q == 4'd15) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            jclk_q  <= 1'b0;
            state_q <= SHIFT_LO;
          end
        end
        DONE: begin
          raw_q      <= frame_d;
          done_q     <= 1'b1;
          prev_q     <= frame_d;
          prev_vld_q <= 1'b1;
          if (take_d) begin
            joy1_q <= joy1_d;
            joy2_q <= joy2_d;
          end
          state_q <= GAP;
        end
        default: state_q <= GAP;
      endcase
    end
  end

  assign JOY_CLK    = jclk_q;
  assign JOY_LOAD   = load_q;
  assign joy1       = joy1_q;
  assign joy2       = joy2_q;
  assign frame_raw  = raw_q;
  assign frame_done = done_q;

endmodule
